// File: rtl/if_queue_pkg.sv
// if_queue_pkg
//   Shared constants and types for the instruction-fetch queue.
//   Default PC / instruction widths mirror the fetch/decode word sizes.
package if_queue_pkg;

  localparam int IFQ_DEPTH       = 4;
  localparam int IFQ_PC_WIDTH    = 32;
  localparam int IFQ_INSTR_WIDTH = 32;

  // Per-cycle queue operation, encoded as {push_fire, pop_fire}.
  typedef enum logic [1:0] {
    IFQ_OP_NONE = 2'b00,
    IFQ_OP_POP  = 2'b01,
    IFQ_OP_PUSH = 2'b10,
    IFQ_OP_BOTH = 2'b11
  } ifq_op_e;

endpackage

// File: rtl/if_queue.sv
// if_queue
//   Instruction-fetch queue between the fetch unit and the IF/ID register.
//   Circular buffer of DEPTH (PC, instruction) pairs; flush empties it in
//   one cycle. No bypass in either direction: every output is a register
//   or a function of registers only.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     discard all entries (redirect); beats push/pop
//   push_vld/push_rdy         fetch-side handshake, push_pc/push_instr data
//   pop_vld/pop_rdy           decode-side handshake, pop_pc/pop_instr data
//   count, full, empty        occupancy status
module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH       = IFQ_DEPTH,
  parameter int PC_WIDTH    = IFQ_PC_WIDTH,
  parameter int INSTR_WIDTH = IFQ_INSTR_WIDTH,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  logic [PC_WIDTH-1:0]    push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [PC_WIDTH-1:0]    pop_pc,
  output logic [INSTR_WIDTH-1:0] pop_instr,
  output logic [CNT_WIDTH-1:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q,  count_d;

  logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

  logic    push_fire, pop_fire;
  ifq_op_e op;

  // Status is decoded from the count register only, so no handshake input
  // reaches an output combinationally.
  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_rdy = !full;
  assign pop_vld  = !empty;
  assign count    = count_q;

  assign pop_pc    = pc_mem_q[rd_ptr_q];
  assign pop_instr = instr_mem_q[rd_ptr_q];

  // flush swallows any same-cycle handshake.
  assign push_fire = push_vld && push_rdy && !flush;
  assign pop_fire  = pop_vld  && pop_rdy  && !flush;
  assign op        = ifq_op_e'({push_fire, pop_fire});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case (op)
        IFQ_OP_PUSH: count_d = count_q + CNT_WIDTH'(1);
        IFQ_OP_POP:  count_d = count_q - CNT_WIDTH'(1);
        default:     count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is zeroed on reset so pop_pc/pop_instr read 0 afterwards;
  // flush leaves contents in place since pop_vld masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push_fire) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, push_vld, push_rdy, pop_vld, pop_rdy, full, empty;
  logic [31:0] push_pc, push_instr, pop_pc, pop_instr;
  logic [2:0]  count;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t exp_q[$];
  int   n;

  if_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_vld(push_vld), .push_rdy(push_rdy), .push_pc(push_pc), .push_instr(push_instr),
    .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model / monitor: at the falling edge inputs and outputs are
  // stable; check status against the model, then apply the coming edge.
  always @(negedge clk) begin
    n = exp_q.size();
    if (rst) begin
      exp_q.delete();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_pop_vld", 64'(pop_vld), 64'd0);
      chk("rst_pop_pc", 64'(pop_pc), 64'd0);
    end else begin
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("push_rdy", 64'(push_rdy), 64'(n < DEPTH));
      chk("pop_vld", 64'(pop_vld), 64'(n > 0));
      if (n > 0) begin
        chk("pop_pc", 64'(pop_pc), 64'(exp_q[0].pc));
        chk("pop_instr", 64'(pop_instr), 64'(exp_q[0].instr));
      end
      if (flush) exp_q.delete();
      else begin
        if (n > 0 && pop_rdy) void'(exp_q.pop_front());
        if (push_vld && n < DEPTH) exp_q.push_back('{push_pc, push_instr});
      end
    end
  end

  task automatic drive(input logic f, input logic pv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic pr);
    flush = f; push_vld = pv; push_pc = pc; push_instr = ins; pop_rdy = pr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0;
    push_pc = '0; push_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_push_rdy", 64'(push_rdy), 64'd1);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_pop_instr", 64'(pop_instr), 64'd0);
    rst = 1'b0;

    // single push, visible next cycle
    drive(1'b0, 1'b1, 32'h100, 32'h3860_0001, 1'b0);
    chk("t1_pop_vld", 64'(pop_vld), 64'd1);
    chk("t1_pop_pc", 64'(pop_pc), 64'h100);
    chk("t1_pop_instr", 64'(pop_instr), 64'h3860_0001);
    chk("t1_count", 64'(count), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // fill, held fifth push, drain in order
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_push_rdy", 64'(push_rdy), 64'd0);
    drive(1'b0, 1'b1, 32'h110, 32'hA000_0004, 1'b0);
    chk("t2_held_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(pop_pc), 64'(32'h100 + 32'(4 * i)));
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    chk("t2_empty", 64'(empty), 64'd1);

    // steady state at count 2 across pointer wrap
    drive(1'b0, 1'b1, 32'h200, 32'hB000_0000, 1'b0);
    drive(1'b0, 1'b1, 32'h204, 32'hB000_0001, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b1, 32'h208 + 32'(4 * i), 32'hB000_0002 + 32'(i), 1'b1);
    chk("t3_count", 64'(count), 64'd2);
    chk("t3_head", 64'(pop_pc), 64'h228);

    // flush at count 3 with push and pop
    drive(1'b0, 1'b1, 32'h300, 32'hC000_0000, 1'b0);
    chk("t4_pre_count", 64'(count), 64'd3);
    drive(1'b1, 1'b1, 32'hDEAD, 32'hDEAD_BEEF, 1'b1);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_push_rdy", 64'(push_rdy), 64'd1);
    drive(1'b0, 1'b1, 32'h400, 32'hC000_0001, 1'b0);
    chk("t4_next_pc", 64'(pop_pc), 64'h400);
    drive(1'b0, 1'b1, 32'h404, 32'hC000_0002, 1'b0);

    // asynchronous reset between edges at count 2
    flush = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_pop_vld", 64'(pop_vld), 64'd0);
    chk("t5_pop_pc", 64'(pop_pc), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h500, 32'hE000_0000, 1'b0);
    chk("t5_first_push", 64'(count), 64'd1);

    // full with pop_rdy and push_vld: only the pop fires
    for (int i = 1; i < 4; i++)
      drive(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0);
    chk("t6_full", 64'(full), 64'd1);
    drive(1'b0, 1'b1, 32'h600, 32'hF000_0000, 1'b1);
    chk("t6_count", 64'(count), 64'd3);
    chk("t6_push_rdy", 64'(push_rdy), 64'd1);
    chk("t6_head", 64'(pop_pc), 64'h504);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
            $urandom, $urandom, ($urandom_range(0, 99) < 60));
    idle();
    // drain
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("final_empty", 64'(empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction-fetch queue between the fetch unit and the IF/ID pipeline register. Buffers up to DEPTH fetched (PC, instruction) pairs so that a decode-side stall does not force the fetch unit to hold its memory request. Decode uses pop_vld/pop_rdy as the write enable of its IF/ID register. A branch redirect empties the queue in one cycle via flush.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2
- PC_WIDTH, 32: width of each stored PC
- INSTR_WIDTH, 32: width of each stored instruction word
- CNT_WIDTH, log2(DEPTH)+1: width of count
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries (branch/exception redirect)
- push_vld  in  1  fetch offers an entry
- push_rdy  out  1  queue can accept an entry
- push_pc  in  PC_WIDTH  PC of offered instruction
- push_instr  in  INSTR_WIDTH  offered instruction word
- pop_vld  out  1  head entry is valid
- pop_rdy  in  1  decode accepts head entry
- pop_pc  out  PC_WIDTH  PC of head entry
- pop_instr  out  INSTR_WIDTH  instruction word of head entry
- count  out  CNT_WIDTH  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Circular buffer: wr_ptr, rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count register of CNT_WIDTH bits.
- push_rdy = !full. Push fires when push_vld && push_rdy; entry written at wr_ptr, wr_ptr += 1.
- pop_vld = !empty. Pop fires when pop_vld && pop_rdy; rd_ptr += 1.
- pop_pc/pop_instr = storage[rd_ptr], combinational from registers. Values are meaningful only while pop_vld = 1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop with 0 < count < DEPTH: both fire and count is unchanged.
- Full: push_rdy = 0 even if pop_rdy = 1 in the same cycle. There is no full-bypass; upstream must hold push_vld and its data.
- Empty: no empty-bypass. A pushed entry becomes visible the cycle after the push.
- flush has priority over push and pop. On flush, wr_ptr, rd_ptr and count are set to 0, and any same-cycle push or pop is discarded. Storage contents are not cleared.
- Reset: wr_ptr = rd_ptr = count = 0 and every storage entry = 0. After reset: push_rdy = 1, pop_vld = 0, full = 0, empty = 1, count = 0, pop_pc = 0, pop_instr = 0.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards all entries. The first push is accepted on the first rising edge after rst deasserts.

## Timing
- Push-to-pop latency is 1 cycle: a push at edge N gives pop_vld = 1 after edge N, so a pop can fire at edge N+1.
- Throughput is 1 push and 1 pop per cycle in steady state.
- All outputs change only on clk edges or on rst. There is no combinational path from push_* or pop_rdy to any output.
- After a flush at edge N: empty = 1 and push_rdy = 1 after edge N, and a push at edge N+1 is accepted.

## Structure
- PC_WIDTH and INSTR_WIDTH defaults come from the shared ppc_defs constants file used by fetch and decode. Nothing new is added there.
- No sub-module. Storage array, pointers and count are inline.
- Decode's IF/ID register instantiates its write-enabled register with wr = pop_vld && pop_rdy && !flush.

## Test plan
- Reset, then push PC 0x100/instr 0x38600001 in one cycle -> next cycle pop_vld = 1, pop_pc = 0x100, pop_instr = 0x38600001, count = 1.
- With pop_rdy = 0, push 4 entries (PC 0x100..0x10C) -> full = 1, push_rdy = 0. A fifth push_vld is held. Then pop 4 entries -> PCs come out in order 0x100, 0x104, 0x108, 0x10C, and empty = 1.
- Continuous push and pop for 10 cycles at count = 2 -> count stays 2, data order is preserved across pointer wrap.
- At count = 3, assert flush together with push_vld and pop_rdy -> next cycle count = 0, empty = 1, and the pushed entry never appears.
- Assert rst asynchronously between edges with count = 2 -> outputs immediately show count = 0, pop_vld = 0, pop_pc = 0.
- At full, pulse pop_rdy with push_vld = 1 -> the pop fires and the push does not. Next cycle push_rdy = 1 and count = 3.
